// File: rtl/pipelined_adder_unit_if.sv
// pipelined_adder_unit_if: operand/result handshake bundle for pipelined_adder_unit
// Signals: inValid/inReady/a/b/inC/sub (operand side), outValid/outReady/s/outC/ovf/zero
//    (result side). a/b/s are declared [0:WIDTH-1], so bit 0 is the MSB.
//    master = producer/consumer side, slave = the adder.
interface pipelined_adder_unit_if #(
   parameter int WIDTH = 32
);
   logic inValid, inReady, inC, sub;
   logic outValid, outReady, outC, ovf, zero;
   logic [0:WIDTH-1] a, b, s;
   modport master (
      output inValid, a, b, inC, sub, outReady,
      input  inReady, outValid, s, outC, ovf, zero
   );
   modport slave (
      input  inValid, a, b, inC, sub, outReady,
      output inReady, outValid, s, outC, ovf, zero
   );
endinterface

// File: rtl/pipelined_adder_unit.sv
// pipelined_adder_unit: STAGES-deep chunked add/subtract with valid/ready handshake
// Ports: clk   - rising-edge clock
//        rst   - asynchronous reset, active low
//        bus   - slave modport: operands inValid/inReady/a/b/inC/sub,
//                results outValid/outReady/s/outC/ovf/zero (bit 0 = MSB)
// Result = a + (sub ? ~b : b) + inC; the LSB chunk is added in stage 0 and each
// stage's carry is registered into the next. The last stage register is the output.
module pipelined_adder_unit #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input logic                   clk,
   input logic                   rst,
   pipelined_adder_unit_if.slave bus
);
   localparam int CW = WIDTH / STAGES;
   logic adv;
   if (WIDTH % STAGES != 0) begin : g_chk
      $error("pipelined_adder_unit: WIDTH must be a multiple of STAGES");
   end
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // UW: operand bits not yet added when a token enters this stage
      localparam int UW = WIDTH - k * CW;
      logic [0:UW-1]         ai, bi;
      logic                  ci, vi;
      logic [CW:0]           sum;
      logic [0:(k+1)*CW-1]   s_d, s_q;
      logic                  c_q, v_q;
      if (k == 0) begin : g_in
         assign ai  = bus.a;
         assign bi  = bus.sub ? ~bus.b : bus.b;
         assign ci  = bus.inC;
         assign vi  = bus.inValid;
         assign s_d = sum[CW-1:0];
      end else begin : g_in
         assign ai  = g_st[k-1].g_up.a_q;
         assign bi  = g_st[k-1].g_up.b_q;
         assign ci  = g_st[k-1].c_q;
         assign vi  = g_st[k-1].v_q;
         // New chunk is more significant than the completed lower chunks
         assign s_d = {sum[CW-1:0], g_st[k-1].s_q};
      end
      assign sum = {1'b0, ai[UW-CW:UW-1]} + {1'b0, bi[UW-CW:UW-1]} + {{CW{1'b0}}, ci};
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= vi;
            c_q <= sum[CW];
            s_q <= s_d;
         end
      end
      if (k < STAGES - 1) begin : g_up
         // Only the still-unadded upper chunks travel forward with the token
         logic [0:UW-CW-1] a_q, b_q;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= ai[0:UW-CW-1];
               b_q <= bi[0:UW-CW-1];
            end
         end
      end else begin : g_out
         logic ovf_q, zero_q;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv) begin
               ovf_q  <= (ai[0] == bi[0]) && (s_d[0] != ai[0]);
               zero_q <= s_d == '0;
            end
         end
      end
   end
   assign adv          = !g_st[STAGES-1].v_q || bus.outReady;
   assign bus.inReady  = adv;
   assign bus.outValid = g_st[STAGES-1].v_q;
   assign bus.s        = g_st[STAGES-1].s_q;
   assign bus.outC     = g_st[STAGES-1].c_q;
   assign bus.ovf      = g_st[STAGES-1].g_out.ovf_q;
   assign bus.zero     = g_st[STAGES-1].g_out.zero_q;
endmodule

// File: tb/tb_pipelined_adder_unit.sv
// tb_pipelined_adder_unit: directed checks of the adder at STAGES = 1, 4 and 8
module tb_pipelined_adder_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b1, in_c = 1'b0, sb = 1'b0;
   logic [0:31] ta = '0, tbb = '0;
   int checks = 0, errors = 0;
   int tx, rx, stall;
   logic [31:0] ev;
   always #5 clk = ~clk;
   pipelined_adder_unit_if #(.WIDTH(32)) i1 ();
   pipelined_adder_unit_if #(.WIDTH(32)) i4 ();
   pipelined_adder_unit_if #(.WIDTH(32)) i8 ();
   assign i1.inValid = in_valid;
   assign i1.a = ta;
   assign i1.b = tbb;
   assign i1.inC = in_c;
   assign i1.sub = sb;
   assign i1.outReady = out_ready;
   assign i4.inValid = in_valid;
   assign i4.a = ta;
   assign i4.b = tbb;
   assign i4.inC = in_c;
   assign i4.sub = sb;
   assign i4.outReady = out_ready;
   assign i8.inValid = in_valid;
   assign i8.a = ta;
   assign i8.b = tbb;
   assign i8.inC = in_c;
   assign i8.sub = sb;
   assign i8.outReady = out_ready;
   pipelined_adder_unit #(.WIDTH(32), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
   pipelined_adder_unit #(.WIDTH(32), .STAGES(4)) u4 (.clk(clk), .rst(rst), .bus(i4));
   pipelined_adder_unit #(.WIDTH(32), .STAGES(8)) u8 (.clk(clk), .rst(rst), .bus(i8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string n, input int stg, input int cyc, input logic v,
                          input logic [31:0] s, input logic c, o, z,
                          input logic [31:0] es, input logic ec, eo, ez);
      chk($sformatf("%s S%0d valid cyc%0d", n, stg, cyc), {31'd0, v}, {31'd0, cyc == stg});
      if (cyc == stg) begin
         chk($sformatf("%s S%0d s", n, stg), s, es);
         chk($sformatf("%s S%0d outC", n, stg), {31'd0, c}, {31'd0, ec});
         chk($sformatf("%s S%0d ovf", n, stg), {31'd0, o}, {31'd0, eo});
         chk($sformatf("%s S%0d zero", n, stg), {31'd0, z}, {31'd0, ez});
      end
   endtask

   // One operand into all three units; called #1 after a rising edge with pipes idle
   task automatic run_single(input string n, input logic [31:0] x, y, input logic ci, sbi,
                             input logic [31:0] es, input logic ec, eo, ez);
      ta = x;
      tbb = y;
      in_c = ci;
      sb = sbi;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk_out(n, 1, cyc, i1.outValid, i1.s, i1.outC, i1.ovf, i1.zero, es, ec, eo, ez);
         chk_out(n, 4, cyc, i4.outValid, i4.s, i4.outC, i4.ovf, i4.zero, es, ec, eo, ez);
         chk_out(n, 8, cyc, i8.outValid, i8.s, i8.outC, i8.ovf, i8.zero, es, ec, eo, ez);
      end
   endtask

   initial begin
      // Asynchronous reset before any clock edge
      #2 rst = 1'b0;
      #1;
      chk("reset outValid", {31'd0, i4.outValid}, 32'd0);
      chk("reset s", i4.s, 32'd0);
      chk("reset flags", {29'd0, i4.outC, i4.ovf, i4.zero}, 32'd0);
      chk("reset inReady", {31'd0, i4.inReady}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;

      run_single("10+5", 32'd10, 32'd5, 1'b0, 1'b0, 32'h0000000F, 1'b0, 1'b0, 1'b0);
      run_single("ffff+1", 32'h0000FFFF, 32'd1, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
      run_single("wrap", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      run_single("ovf", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      run_single("10-31", 32'd10, 32'd31, 1'b1, 1'b1, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0);

      // Stream five operands through the 4-stage unit, stalling the first result 3 cycles
      tx = 0;
      rx = 0;
      stall = 3;
      in_c = 1'b0;
      sb = 1'b0;
      for (int c = 0; c < 40 && rx < 5; c++) begin
         in_valid = tx < 5;
         ta = 32'(32'h0000FFFF * (tx + 1));
         tbb = 32'(32'h12345678 + tx);
         out_ready = !(i4.outValid && rx == 0 && stall > 0);
         if (!out_ready) stall--;
         #1;
         if (!out_ready) chk("stall inReady", {31'd0, i4.inReady}, 32'd0);
         if (i4.outValid) begin
            ev = 32'(32'h0000FFFF * (rx + 1) + 32'h12345678 + rx);
            chk($sformatf("stream s%0d", rx), i4.s, ev);
            if (out_ready) rx++;
         end
         if (in_valid && i4.inReady) tx++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("stream results", rx, 32'd5);
      chk("stream accepted", tx, 32'd5);
      chk("stream stall used", stall, 32'd0);
      chk("stream no duplicate", {31'd0, i4.outValid}, 32'd0);
      repeat (10) @(posedge clk);
      #1;

      // Three tokens in flight, then reset mid-operation
      for (int i = 0; i < 3; i++) begin
         ta = 32'(i + 1);
         tbb = 32'd1;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("pre-reset S1 s", i1.s, 32'd4);
      chk("pre-reset S1 valid", {31'd0, i1.outValid}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mid-reset S1 valid", {31'd0, i1.outValid}, 32'd0);
      chk("mid-reset S1 s", i1.s, 32'd0);
      chk("mid-reset S4 valid", {31'd0, i4.outValid}, 32'd0);
      chk("mid-reset S4 s", i4.s, 32'd0);
      chk("mid-reset S4 inReady", {31'd0, i4.inReady}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post-reset stale S4 c%0d", i), {31'd0, i4.outValid}, 32'd0);
         chk($sformatf("post-reset stale S8 c%0d", i), {31'd0, i8.outValid}, 32'd0);
      end
      run_single("1+1", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipelined_adder_unit.md
Name: pipelined_adder_unit

Overview:
- Parametrised, pipelined successor to the combinational adder unit.
- Splits a WIDTH-bit add/subtract into STAGES equal chunks, one chunk per clock. Each chunk's carry is registered into the next stage.
- Valid/ready handshake on input and output, with global backpressure.
- Produces sum, carry-out, signed overflow and zero flags. Used by the execute stage for multi-cycle wide arithmetic and as a timing-relief replacement for the single-cycle adder.

Parameters:
- WIDTH, 32, operand/result width in bits; bit 0 is the MSB.
- STAGES, 4, pipeline depth; must divide WIDTH evenly. Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock, rising edge active.
- rst  input  1  asynchronous reset, active low.
- inValid  input  1  operand set on a/b/inC/sub is valid.
- inReady  output  1  unit accepts operands this cycle.
- a  input  WIDTH  operand A, [0:WIDTH-1].
- b  input  WIDTH  operand B, [0:WIDTH-1].
- inC  input  1  carry in.
- sub  input  1  0 = add, 1 = subtract (B inverted).
- outValid  output  1  result outputs are valid.
- outReady  input  1  consumer takes the result this cycle.
- s  output  WIDTH  result, [0:WIDTH-1].
- outC  output  1  carry out of bit 0.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  s equals 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports clk and rst.
- Arithmetic: result = a + (sub ? ~b : b) + inC, computed modulo 2^WIDTH.
  - inC is not forced for subtract. The caller drives inC=1 for a plain subtract, or the borrow for subtract-with-borrow.
  - outC is the carry out of bit 0. For subtract, outC=1 means no borrow.
  - ovf = (A0 == B'0) && (s0 != A0), where B' is the possibly inverted b.
  - zero = (s == 0), computed on the final sum only.
- Stage k (k=0..STAGES-1) adds chunk bits [WIDTH-(k+1)*CW : WIDTH-k*CW-1], so the LSB chunk goes first. Carry-in is inC for k=0, else the registered carry of stage k-1.
- Upper, not-yet-added chunks of a and B' travel with the token in pipeline registers. Completed lower sum chunks are carried forward.
- Advance: adv = !outValid || outReady.
  - inReady = adv, combinational from outValid/outReady.
  - All stage registers, valid bits and outputs load only when adv=1, otherwise they hold.
  - An operand is accepted when inValid && inReady.
- Bubbles are not compacted. A stage with valid=0 shifts like any other.
- Latency: an operand accepted in cycle N appears with outValid=1 after the edge ending cycle N+STAGES-1 when adv stays 1. STAGES=1 gives 1 cycle.
- Throughput: one result per cycle with outReady held high.
- Backpressure: with outValid=1 and outReady=0, s/outC/ovf/zero/outValid are held stable, inReady=0, and nothing is accepted.
- Simultaneous events: a result consumed and a new operand accepted in the same cycle is legal and is the normal streaming case.
- Reset (any time, including mid-operation): all valid bits, s, outC, ovf and zero go to 0 immediately; inReady reads 1. In-flight tokens are discarded, with no partial result emitted.
- Outputs are registered. No combinational path from a/b to s.
- Elaboration: a WIDTH % STAGES != 0 configuration is an elaboration error (generate-time check).

Test Plan (WIDTH=32, STAGES=4, outReady=1 unless stated):
- 10 + 5, inC=0, sub=0 -> s=0x0000000F, outC=0, ovf=0, zero=0; outValid exactly 4 cycles after acceptance.
- 0x0000FFFF + 1 -> s=0x00010000, proving the inter-stage carry. 0xFFFFFFFF + 1 -> s=0, outC=1, zero=1, ovf=0.
- 0x7FFFFFFF + 1 -> s=0x80000000, ovf=1, outC=0. Subtract 10 - 31 with sub=1, inC=1 -> s=0xFFFFFFEB, outC=0, ovf=0.
- Stream 5 back-to-back operands; hold outReady=0 for 3 cycles after the first result -> the first result is held stable, inReady=0, and all 5 results later emerge in order with no loss or duplication.
- Assert rst low while 3 tokens are in flight -> outValid=0 and s=0 immediately, with no stale result after release. The next operand 1+1 -> s=2 after 4 cycles.
- Re-run the first and third scenarios with STAGES=1 and STAGES=8 -> identical results; latency is 1 and 8 cycles respectively.
